// File: rtl/zbt_addr_calc.sv
`default_nettype none
// ============================================================================
// Module   : zbt_addr_calc
// Brief    : ZBT word-address generator for the audio store; tracks the
//            sample phase, word offset and per-song recorded length.
// Revision : 1.0 - initial release
// ============================================================================
module zbt_addr_calc #(
  parameter int OFFSET_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  input  logic                  start_song,
  input  logic [3:0]            song_choice,
  input  logic                  record_mode,
  input  logic                  pause_song,
  output logic [OFFSET_W+2:0]   addr,
  output logic                  bank_sel,
  output logic                  song_done,
  output logic [OFFSET_W-1:0]   offset
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cur_song;
  logic                  r_cur_rec;
  logic [1:0]            r_phase;
  logic [OFFSET_W-1:0]   r_offset;
  logic [OFFSET_W:0]     r_len [16];
  logic                  r_song_done;

  logic                  w_step;
  logic                  w_word_adv;
  logic [OFFSET_W:0]     w_offset_inc;
  logic                  w_at_end;

  // start_song pre-empts a coincident ready, so the step is masked by it
  assign w_step       = (r_state == S_ACTIVE) && ready && !pause_song && !start_song;
  assign w_word_adv   = w_step && (r_phase == 2'd2);
  assign w_offset_inc = {1'b0, r_offset} + {{OFFSET_W{1'b0}}, 1'b1};
  assign w_at_end     = r_cur_rec ? (r_offset == {OFFSET_W{1'b1}})
                                  : (w_offset_inc == r_len[r_cur_song]);

  always_comb begin
    w_next_state = r_state;
    if (start_song) begin
      if (!record_mode && (r_len[song_choice] == '0))
        w_next_state = S_DONE;
      else
        w_next_state = S_ACTIVE;
    end else if (w_word_adv && w_at_end) begin
      w_next_state = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cur_song  <= 4'd0;
      r_cur_rec   <= 1'b0;
      r_phase     <= 2'd0;
      r_offset    <= '0;
      r_song_done <= 1'b1;
      for (int i = 0; i < 16; i++) r_len[i] <= '0;
    end else begin
      r_song_done <= (w_next_state != S_ACTIVE);
      if (start_song) begin
        r_cur_song <= song_choice;
        r_cur_rec  <= record_mode;
        r_phase    <= 2'd0;
        r_offset   <= '0;
        if (record_mode) r_len[song_choice] <= '0;
      end else if (w_step) begin
        r_phase <= w_word_adv ? 2'd0 : r_phase + 2'd1;
        if (w_word_adv) begin
          if (r_cur_rec) r_len[r_cur_song] <= w_offset_inc;
          // the terminating word holds its offset so addr stays on the last word
          if (!w_at_end) r_offset <= w_offset_inc[OFFSET_W-1:0];
        end
      end
    end
  end

  assign addr      = {r_cur_song[2:0], r_offset};
  assign bank_sel  = r_cur_song[3];
  assign song_done = r_song_done;
  assign offset    = r_offset;

endmodule
`default_nettype wire

// File: tb/tb_zbt_addr_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_zbt_addr_calc
// Brief    : Directed vector bench for zbt_addr_calc (OFFSET_W=16 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_zbt_addr_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        start_song;
  logic [3:0]  song_choice;
  logic        record_mode;
  logic        pause_song;

  logic [18:0] addr16;
  logic        bank16, done16;
  logic [15:0] off16;
  logic [6:0]  addr4;
  logic        bank4, done4;
  logic [3:0]  off4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  zbt_addr_calc #(.OFFSET_W(16)) dut16 (
    .clk(clk), .reset(reset), .ready(ready), .start_song(start_song),
    .song_choice(song_choice), .record_mode(record_mode), .pause_song(pause_song),
    .addr(addr16), .bank_sel(bank16), .song_done(done16), .offset(off16)
  );

  zbt_addr_calc #(.OFFSET_W(4)) dut4 (
    .clk(clk), .reset(reset), .ready(ready), .start_song(start_song),
    .song_choice(song_choice), .record_mode(record_mode), .pause_song(pause_song),
    .addr(addr4), .bank_sel(bank4), .song_done(done4), .offset(off4)
  );

  typedef struct {
    logic        st;
    logic [3:0]  ch;
    logic        rec;
    logic        pa;
    logic        rd;
    logic [18:0] e_addr;
    logic        e_done;
    logic        e_bank;
    logic [15:0] e_off;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Idle 3 cycles (keeps ready spacing >= 4), pulse for one cycle, sample at next negedge
  task automatic apply(input logic st, input logic [3:0] ch, input logic rec,
                       input logic pa, input logic rd);
    repeat (3) @(negedge clk);
    start_song  = st;
    song_choice = ch;
    record_mode = rec;
    pause_song  = pa;
    ready       = rd;
    @(negedge clk);
    start_song  = 1'b0;
    ready       = 1'b0;
    pause_song  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ready = 1'b0; start_song = 1'b0;
    song_choice = 4'd0; record_mode = 1'b0; pause_song = 1'b0;

    vecs[0]  = '{1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 19'h20000, 1'b0, 1'b1, 16'd0};
    vecs[1]  = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 19'h20000, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 19'h20000, 1'b0, 1'b1, 16'd0};
    vecs[3]  = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 19'h20001, 1'b0, 1'b1, 16'd1};
    vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 19'h20001, 1'b0, 1'b1, 16'd1};
    vecs[5]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 19'h20001, 1'b0, 1'b1, 16'd1};
    vecs[6]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 19'h20001, 1'b0, 1'b1, 16'd1};
    vecs[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 19'h20001, 1'b0, 1'b1, 16'd1};
    vecs[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 19'h20001, 1'b0, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 19'h20002, 1'b0, 1'b1, 16'd2};
    vecs[10] = '{1'b1, 4'b1010, 1'b1, 1'b0, 1'b1, 19'h20000, 1'b0, 1'b1, 16'd0};
    vecs[11] = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 19'h20000, 1'b0, 1'b1, 16'd0};
    vecs[12] = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 19'h20000, 1'b0, 1'b1, 16'd0};
    vecs[13] = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 19'h20001, 1'b0, 1'b1, 16'd1};

    repeat (3) @(negedge clk);
    chk("rst addr",   {13'd0, addr16}, 32'h0);
    chk("rst done",   {31'd0, done16}, 32'd1);
    chk("rst bank",   {31'd0, bank16}, 32'd0);
    chk("rst offset", {16'd0, off16},  32'd0);
    chk("rst done4",  {31'd0, done4},  32'd1);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].st, vecs[i].ch, vecs[i].rec, vecs[i].pa, vecs[i].rd);
      chk($sformatf("vec%0d addr", i),   {13'd0, addr16}, {13'd0, vecs[i].e_addr});
      chk($sformatf("vec%0d done", i),   {31'd0, done16}, {31'd0, vecs[i].e_done});
      chk($sformatf("vec%0d bank", i),   {31'd0, bank16}, {31'd0, vecs[i].e_bank});
      chk($sformatf("vec%0d offset", i), {16'd0, off16},  {16'd0, vecs[i].e_off});
    end

    // Record 30 samples into song 10
    apply(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
    chk("rec start addr", {13'd0, addr16}, 32'h20000);
    for (int n = 1; n <= 30; n++) begin
      apply(1'b0, 4'b1010, 1'b1, 1'b0, 1'b1);
      chk($sformatf("rec r%0d addr", n), {13'd0, addr16}, 32'h20000 + n / 3);
      chk($sformatf("rec r%0d done", n), {31'd0, done16}, 32'd0);
    end

    // Play it back: ends on ready 30 with offset held at 9
    apply(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
    chk("play start done", {31'd0, done16}, 32'd0);
    chk("play start addr", {13'd0, addr16}, 32'h20000);
    for (int n = 1; n <= 30; n++) begin
      apply(1'b0, 4'b1010, 1'b0, 1'b0, 1'b1);
      chk($sformatf("play r%0d done", n), {31'd0, done16}, (n == 30) ? 32'd1 : 32'd0);
      chk($sformatf("play r%0d offset", n), {16'd0, off16}, (n == 30) ? 32'd9 : n / 3);
    end
    apply(1'b0, 4'b1010, 1'b0, 1'b0, 1'b1);
    chk("play frozen done",   {31'd0, done16}, 32'd1);
    chk("play frozen offset", {16'd0, off16},  32'd9);

    // Empty song playback
    apply(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
    chk("empty done", {31'd0, done16}, 32'd1);
    chk("empty addr", {13'd0, addr16}, 32'h30000);
    chk("empty bank", {31'd0, bank16}, 32'd0);

    // Full region on the 4-bit instance, record then playback
    apply(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 48; n++) begin
      apply(1'b0, 4'b0101, 1'b1, 1'b0, 1'b1);
      chk($sformatf("full rec r%0d off4", n), {28'd0, off4}, (n / 3 > 15) ? 32'd15 : n / 3);
      chk($sformatf("full rec r%0d done4", n), {31'd0, done4}, (n == 48) ? 32'd1 : 32'd0);
    end
    chk("full rec addr4", {25'd0, addr4}, 32'h5F);
    apply(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
    chk("full play start done4", {31'd0, done4}, 32'd0);
    for (int n = 1; n <= 48; n++) begin
      apply(1'b0, 4'b0101, 1'b0, 1'b0, 1'b1);
      chk($sformatf("full play r%0d done4", n), {31'd0, done4}, (n == 48) ? 32'd1 : 32'd0);
    end
    chk("full play off4", {28'd0, off4}, 32'd15);

    // Reset mid-record clears the length table
    apply(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 6; n++) apply(1'b0, 4'b0110, 1'b1, 1'b0, 1'b1);
    chk("midrec addr", {13'd0, addr16}, 32'h60002);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst done",   {31'd0, done16}, 32'd1);
    chk("midrst addr",   {13'd0, addr16}, 32'h0);
    chk("midrst offset", {16'd0, off16},  32'd0);
    chk("midrst bank",   {31'd0, bank16}, 32'd0);
    reset = 1'b1;
    apply(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
    chk("post-rst play done",  {31'd0, done16}, 32'd1);
    chk("post-rst play addr",  {13'd0, addr16}, 32'h20000);
    chk("post-rst play done4", {31'd0, done4},  32'd1);
    apply(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
    chk("post-rst play5 done4", {31'd0, done4}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
